// File: rtl/cell_sweep_pkg.sv
// Shared types and constants for the standard-cell sweep driver.
// Truth tables are indexed by input vector, MSB = first listed pin.
package cell_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    DONE
  } sweep_state_e;

  localparam int unsigned SETTLE_W = 8;

  localparam logic [15:0] OAI22_EXPECT = 16'h111F;
  localparam logic [15:0] AOI22_EXPECT = 16'h0777;
  localparam logic [3:0]  NAND2_EXPECT = 4'h7;
  localparam logic [3:0]  NOR2_EXPECT  = 4'h1;
  localparam logic [1:0]  INV_EXPECT   = 2'h1;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-time down-counter: loads SETTLE-1 and pulses expire_o on the
// last hold cycle of each vector, reloading itself for the next one.
module sweep_settle_timer
  import cell_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    expire_o = en_i && (cnt_q == '0);
    cnt_d    = cnt_q;
    if (load_i || expire_o) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cell_sweep_driver.sv
// Exhaustive ascending-vector sweep of an N-input cell with truth-table check.
// Optional build macro SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module cell_sweep_driver
  import cell_sweep_pkg::*;
#(
  parameter int unsigned         N_IN   = 4,
  parameter int unsigned         SETTLE = 10,
  parameter logic [2**N_IN-1:0]  EXPECT = OAI22_EXPECT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            resp_i,
  output logic [N_IN-1:0] vec_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            first_fail_vld,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

  sweep_state_e    state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffi_q, ffi_d;

  logic accept, expire, mismatch, last_vec, stop_hit, finish, applying;

  assign applying = (state_q == APPLY);
  assign accept   = start && !applying;
  // Case inequality so an unknown cell output is never mistaken for a match.
  assign mismatch = (resp_i !== EXPECT[vec_q]);
  assign last_vec = (vec_q == '1);
`ifdef SWEEP_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif
  assign finish   = expire && (last_vec || stop_hit);

  sweep_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .en_i     (applying),
    .expire_o (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = APPLY;
      APPLY:      if (finish) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    vec_o          = vec_q;
    busy           = applying;
    done           = (state_q == DONE);
    pass           = done && (err_q == '0);
    err_cnt        = err_q;
    first_fail_vld = ffv_q;
    first_fail_idx = ffi_q;
  end

  always_comb begin
    vec_d = vec_q;
    err_d = err_q;
    ffv_d = ffv_q;
    ffi_d = ffi_q;
    if (accept) begin
      vec_d = '0;
      err_d = '0;
      ffv_d = 1'b0;
      ffi_d = '0;
    end else if (expire) begin
      if (mismatch) begin
        if (err_q != ERR_MAX) err_d = err_q + 1'b1;
        if (!ffv_q) begin
          ffv_d = 1'b1;
          ffi_d = vec_q;
        end
      end
      vec_d = finish ? '0 : vec_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      err_q <= '0;
      ffv_q <= 1'b0;
      ffi_q <= '0;
    end else begin
      vec_q <= vec_d;
      err_q <= err_d;
      ffv_q <= ffv_d;
      ffi_q <= ffi_d;
    end
  end

endmodule

// File: tb/tb_cell_sweep_driver.sv
// Self-checking bench for cell_sweep_driver: OAI22 default instance driven by a
// response table (correct or faulted), plus a SETTLE=1 NAND2 instance.
module tb_cell_sweep_driver;

  localparam int          S   = 10;
  localparam logic [15:0] EXP = 16'h111F;
`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, resp_i;
  logic [3:0]  vec_o, first_fail_idx;
  logic        busy, done, pass, first_fail_vld;
  logic [4:0]  err_cnt;
  logic [15:0] cur_tbl;

  logic        start2, resp2;
  logic [1:0]  vec2, ffi2;
  logic        busy2, done2, pass2, ffv2;
  logic [2:0]  err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Cell models: the faulted/correct OAI22 lookup and a true NAND2 gate.
  assign resp_i = cur_tbl[vec_o];
  assign resp2  = ~(vec2[1] & vec2[0]);

  cell_sweep_driver u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_i(resp_i), .vec_o(vec_o),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx)
  );

  cell_sweep_driver #(.N_IN(2), .SETTLE(1), .EXPECT(4'h7)) u_nand (
    .clk(clk), .rst_n(rst_n), .start(start2), .resp_i(resp2), .vec_o(vec2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .first_fail_vld(ffv2), .first_fail_idx(ffi2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".vec"}, 32'(vec_o), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".pass"}, 32'(pass), 0);
    chk({tag, ".err"}, 32'(err_cnt), 0);
    chk({tag, ".ffv"}, 32'(first_fail_vld), 0);
    chk({tag, ".ffi"}, 32'(first_fail_idx), 0);
    chk({tag, ".busy2"}, 32'(busy2), 0);
    chk({tag, ".done2"}, 32'(done2), 0);
  endtask

  // Cycles from the accepting edge until the sweep ends for response table tbl.
  function automatic int sweep_len(input logic [15:0] tbl);
    for (int i = 0; i < 16; i++)
      if (STOP && tbl[i] != EXP[i]) return (i + 1) * S;
    return 16 * S;
  endfunction

  // Expected outputs c cycles after the accepting edge of a sweep lasting e cycles.
  task automatic check_state(input string tag, input int c, input int e, input logic [15:0] tbl);
    int ns, cnt, first;
    ns    = ((c > e) ? e : c) / S;
    cnt   = 0;
    first = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < ns && tbl[i] != EXP[i]) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    if (c < e) begin
      chk({tag, ".busy"}, 32'(busy), 1);
      chk({tag, ".done"}, 32'(done), 0);
      chk({tag, ".pass"}, 32'(pass), 0);
      chk({tag, ".vec"}, 32'(vec_o), 32'(c / S));
    end else begin
      chk({tag, ".busy"}, 32'(busy), 0);
      chk({tag, ".done"}, 32'(done), 1);
      chk({tag, ".pass"}, 32'(pass), (cnt == 0) ? 1 : 0);
      chk({tag, ".vec"}, 32'(vec_o), 0);
    end
    chk({tag, ".err"}, 32'(err_cnt), 32'(cnt));
    chk({tag, ".ffv"}, 32'(first_fail_vld), (cnt > 0) ? 1 : 0);
    chk({tag, ".ffi"}, 32'(first_fail_idx), 32'(first));
  endtask

  task automatic run_sweep(input string tag, input logic [15:0] tbl, input bit noisy);
    int e;
    e       = sweep_len(tbl);
    cur_tbl = tbl;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_state({tag, ".acc"}, 0, e, tbl);
    for (int c = 1; c <= e + 2; c++) begin
      @(negedge clk);
      start = (noisy && c <= e) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      check_state(tag, c, e, tbl);
    end
    start = 1'b0;
  endtask

  initial begin
    logic [15:0] tbl;
    rst_n   = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    cur_tbl = EXP;
    #3;
    check_reset("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset("idle");

    run_sweep("good", EXP, 1'b0);

    run_sweep("const1", 16'hFFFF, 1'b0);
    chk("const1.err_final", 32'(err_cnt), STOP ? 1 : 9);
    chk("const1.ffi_final", 32'(first_fail_idx), 5);

    run_sweep("noisy", 16'hFFFF, 1'b1);
    run_sweep("rerun", EXP, 1'b0);

    // Asynchronous reset in the middle of vector 7.
    cur_tbl = EXP;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7 * S + 3) @(posedge clk);
    #1;
    chk("midrst.vec_before", 32'(vec_o), 7);
    #2 rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("postrst");
    run_sweep("afterrst", EXP, 1'b0);

    for (int n = 0; n < 6; n++) begin
      tbl = EXP ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      run_sweep($sformatf("rand%0d", n), tbl, 1'($urandom_range(0, 1)));
    end
    run_sweep("fullflip", ~EXP, 1'b0);

    @(negedge clk) start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    chk("nand.busy0", 32'(busy2), 1);
    chk("nand.vec0", 32'(vec2), 0);
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("nand.busy%0d", c), 32'(busy2), 1);
      chk($sformatf("nand.vec%0d", c), 32'(vec2), 32'(c));
    end
    @(posedge clk); #1;
    chk("nand.done", 32'(done2), 1);
    chk("nand.busy_end", 32'(busy2), 0);
    chk("nand.pass", 32'(pass2), 1);
    chk("nand.err", 32'(err2), 0);
    chk("nand.ffv", 32'(ffv2), 0);
    chk("nand.vec_end", 32'(vec2), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_sweep_driver.md
# cell_sweep_driver

Stimulus-and-check stage that sits directly upstream of a standard-cell instance under test (e.g. OAI22_X2). It walks every input combination of an N-input cell in ascending binary order, holds each vector for a programmable settle time, samples the cell output, and compares it against an expected truth table. Pass/fail, mismatch count and first failing vector are reported. This replaces hand-written per-cell vector lists with one reusable, self-checking block.

## Interface
- N_IN, 4, number of cell inputs; vec_o[N_IN-1] drives the first listed pin (A1), vec_o[0] the last (B2)
- SETTLE, 10, cycles each vector is held before sampling; legal range 1..255
- EXPECT, 16'h111F, expected output per vector index; bit i = expected resp_i for vec_o == i (default is the OAI22 truth table)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE or DONE
- resp_i  in  1  cell output (ZN)
- vec_o  out  N_IN  cell input vector
- busy  out  1  high while a sweep is in progress
- done  out  1  high from sweep completion until the next accepted start
- pass  out  1  valid when done; 1 iff err_cnt == 0
- err_cnt  out  N_IN+1  mismatch count, saturating at 2^N_IN
- first_fail_vld  out  1  a mismatch has been recorded this sweep
- first_fail_idx  out  N_IN  vector index of the first mismatch

## Operation
- States: IDLE, APPLY, DONE.
- IDLE: entered on reset. start=1 -> APPLY, and vec_o, err_cnt, first_fail_* are cleared.
- APPLY: vec_o is held for SETTLE cycles. On the last cycle of the hold, resp_i is compared to EXPECT[vec_o].
  - On a mismatch, err_cnt increments.
  - On the first mismatch, first_fail_idx = vec_o and first_fail_vld = 1.
  - If vec_o == 2^N_IN-1, go to DONE. Otherwise vec_o increments and the settle count restarts.
- DONE: done=1. vec_o returns to 0. Results are held. start=1 -> a new sweep begins with the same clearing as from IDLE.
- start while busy: ignored, with no effect on the sweep.
- Compare rule: an X or Z on resp_i counts as a mismatch.
- vec_o wraps only by returning to 0 in DONE. It never increments past 2^N_IN-1.

## Timing
- Reset values: vec_o=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vld=0, first_fail_idx=0.
- start accepted at edge k:
  - busy=1 and vec_o=0 are visible after edge k.
  - Vector i is driven during cycles k+1+i·SETTLE through k+(i+1)·SETTLE.
  - resp_i for vector i is sampled at edge k+(i+1)·SETTLE.
- done/pass rise and busy falls after edge k+2^N_IN·SETTLE. With the defaults this is 160 cycles after start.
- err_cnt and first_fail_* update the cycle after the sampling edge.
- rst_n low mid-sweep: all outputs go immediately (asynchronously) to reset values. The sweep is abandoned, and a fresh start is required after release.

## Configuration
- SWEEP_STOP_ON_FAIL_EN defined:
  - The first mismatch goes straight to DONE with pass=0 and err_cnt=1.
  - vec_o returns to 0.
  - first_fail_idx names the failing vector.
- Undefined: the full sweep always runs and err_cnt counts all mismatches.

## Structure
- Package cell_sweep_pkg:
  - state enum (IDLE/APPLY/DONE)
  - truth-table constants for bench cells (OAI22_EXPECT = 16'h111F, plus AOI22, NAND2 and the others as added)
  - settle-counter width constant (8 bits)
- One sub-module, sweep_settle_timer:
  - loadable down-counter from SETTLE-1
  - one-cycle expire pulse that drives the sample/advance decision
- The FSM, vector counter and result registers live in the top module.

## Test plan
- Correct OAI22 model, defaults, start pulse → 16 vectors 0000..1111 each held 10 cycles; done after 160 cycles; pass=1, err_cnt=0, first_fail_vld=0.
- resp_i forced to constant 1 → mismatches on indices 5,6,7,9,10,11,13,14,15; err_cnt=9, first_fail_idx=5, pass=0.
- Same as above with SWEEP_STOP_ON_FAIL_EN → done after vector 5 is sampled (cycle 60); err_cnt=1, first_fail_idx=5, vec_o=0.
- rst_n pulsed low during vector 7 → all outputs go to reset values at once; a new start then completes with pass=1.
- start pulsed repeatedly while busy, then once in DONE → the first sweep is unaffected; the second sweep clears results and repeats the 160-cycle run.
- SETTLE=1, N_IN=2, EXPECT=4'h7 with a NAND2 model → done 4 cycles after start, pass=1.
